rr_arbiter_4: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_prio_enc_4.sv | 30 +++
 rtl/rr_arbiter_4.sv | 90 +++++++++
 tb/tb_rr_arbiter_4.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the four-client round-robin arbiter and its priority encoder.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Starting from 3 makes client 0 the first candidate after reset.
  localparam logic [IDX_W-1:0] LAST_IDX_RST = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_prio_enc_4.sv
// Rotating priority encoder: picks the first set request bit searching upward
// from base+1, wrapping modulo 4.
module rr_prio_enc_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    any   = |req;
    // Offset 4 wraps back onto base itself, so a lone request at base still wins.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = base + i[IDX_W-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot and encoded grant.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD consecutive cycles.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
    $error("rr_arbiter_4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             hold_expired;

  rr_prio_enc_4 u_prio_enc (
    .req  (req),
    .base (last_idx),
    .pick (pick),
    .any  (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign hold_expired = (hold_cnt == HOLD_LAST);

  // Counter sits at zero in IDLE, so the first GRANT cycle counts as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == GRANT) && req[gnt_idx] && hold_expired;
      hold_cnt  <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_idx <= LAST_IDX_RST;
      gnt      <= '0;
      gnt_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= idx_to_onehot(pick);
            gnt_idx  <= pick;
            last_idx <= pick;
            state    <= GRANT;
          end
        end
        default: begin
          // A revoked owner keeps last_idx, so other waiting clients go first.
          if (!req[gnt_idx] || hold_expired) begin
            gnt     <= '0;
            gnt_idx <= '0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: expected grant states are queued as
// stimulus is applied and compared one cycle later against the outputs.
module tb_rr_arbiter_4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] g, input logic to);
    obs_t o;
    o.gnt   = g;
    o.valid = (g != 4'b0000);
    o.to    = to;
    case (g)
      4'b0010: o.idx = 2'd1;
      4'b0100: o.idx = 2'd2;
      4'b1000: o.idx = 2'd3;
      default: o.idx = 2'd0;
    endcase
    return o;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.gnt   = gnt;
    o.idx   = gnt_idx;
    o.valid = gnt_valid;
    o.to    = timeout;
    return o;
  endfunction

  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    exp_q.push_back(mk(4'b0000, 1'b0));
    tick(4'b1111);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("[TB] FAIL reset: got %b want %b", observed(), e);
    end
    rst = 1'b0;
    tick(4'b0000);
  endtask

  task automatic test_single();
    obs_t e;
    logic [3:0] r_seq [3] = '{4'b0001, 4'b0001, 4'b0000};
    logic [3:0] g_seq [3] = '{4'b0001, 4'b0001, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(g_seq[i], 1'b0));
      tick(r_seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL single step %0d: got %b want %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_rotation();
    obs_t e;
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    tick(4'b0000);
    rst = 1'b0;
    foreach (order[k]) begin
      for (int c = 0; c < 4; c++) begin
        if (c < 3) begin
          exp_q.push_back(mk(4'b0001 << order[k], 1'b0));
          tick(4'b1111);
        end else begin
          exp_q.push_back(mk(4'b0000, 1'b0));
          tick(4'b1111 & ~(4'b0001 << order[k]));
        end
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          failures++;
          $display("[TB] FAIL rotation grant %0d cycle %0d: got %b want %b", k, c, observed(), e);
        end
      end
    end
  endtask

  task automatic test_ignore_others();
    obs_t e;
    logic [3:0] r_seq [5] = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] g_seq [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(g_seq[i], 1'b0));
      tick(r_seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL ignore_others step %0d: got %b want %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_self_wrap();
    obs_t e;
    logic [3:0] r_seq [8] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000,
                              4'b1000, 4'b0000, 4'b1001, 4'b0000};
    logic [3:0] g_seq [8] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000,
                              4'b1000, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(g_seq[i], 1'b0));
      tick(r_seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL self_wrap step %0d: got %b want %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e;
    logic [3:0] r_seq [4] = '{4'b0100, 4'b0100, 4'b1010, 4'b0000};
    logic [3:0] g_seq [4] = '{4'b0100, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      rst = (i == 1);
      exp_q.push_back(mk(g_seq[i], 1'b0));
      tick(r_seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL reset_mid_grant step %0d: got %b want %b", i, observed(), e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hold_limit();
    obs_t e;
    rst = 1'b1;
    tick(4'b0000);
    rst = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(4'b0001, 1'b0));
    exp_q.push_back(mk(4'b0000, 1'b1));
    exp_q.push_back(mk(4'b0010, 1'b0));
    exp_q.push_back(mk(4'b0010, 1'b0));
    for (int i = 0; i < 7; i++) begin
      tick(4'b0011);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL timeout step %0d: got %b want %b", i, observed(), e);
      end
    end
`else
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(mk(4'b0001, 1'b0));
      tick(4'b0011);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("[TB] FAIL hold_forever cycle %0d: got %b want %b", i, observed(), e);
      end
    end
`endif
    exp_q.push_back(mk(4'b0000, 1'b0));
    tick(4'b0000);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("[TB] FAIL hold_release: got %b want %b", observed(), e);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_ignore_others();
    test_self_wrap();
    test_reset_mid_grant();
    test_hold_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
